// File: rtl/r_c_n_bit_serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// Port ov exists only when SUB_OVERFLOW_EN is defined.
interface r_c_n_bit_serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             z;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b;
`ifdef SUB_OVERFLOW_EN
    logic             ov;
`endif

    modport master (
        output start, x, y, z,
        input  ready, busy, done, d, b
`ifdef SUB_OVERFLOW_EN
        , input ov
`endif
    );

    modport slave (
        input  start, x, y, z,
        output ready, busy, done, d, b
`ifdef SUB_OVERFLOW_EN
        , output ov
`endif
    );
endinterface

// File: rtl/r_c_n_bit_serial_subtractor.sv
// Multi-cycle ripple-borrow subtractor d = x - y - z, DIGIT bits per clock.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ov.
module r_c_n_bit_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                          clk,
    input logic                          rst,
    r_c_n_bit_serial_subtractor_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] x_sh_reg, y_sh_reg;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] d_reg;
    logic             br_reg, b_reg;
    logic [DIGIT-1:0] diff;
    logic [DIGIT:0]   bchain;
    logic             ready_c, busy_c, done_c;
    logic             accept, last;
`ifdef SUB_OVERFLOW_EN
    logic             xm_reg, ym_reg, ov_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        ready_c    = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) state_next = RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                ready_c    = 1'b1;
                done_c     = 1'b1;
                state_next = bus.start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = bus.start & ready_c;
    assign last   = (cnt_reg == CW'(N - 1));

    // One DIGIT-wide slice of full subtractors; borrow ripples combinationally.
    assign bchain[0] = br_reg;
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        assign diff[gi]     = x_sh_reg[gi] ^ y_sh_reg[gi] ^ bchain[gi];
        assign bchain[gi+1] = (~x_sh_reg[gi] & y_sh_reg[gi]) |
                              (~x_sh_reg[gi] & bchain[gi])   |
                              ( y_sh_reg[gi] & bchain[gi]);
    end

    // Result slices are written in place so the final word needs no realignment.
    always_comb begin
        acc_next = acc_reg;
        acc_next[int'(cnt_reg) * DIGIT +: DIGIT] = diff;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            x_sh_reg <= '0;
            y_sh_reg <= '0;
            br_reg   <= 1'b0;
            acc_reg  <= '0;
            d_reg    <= '0;
            b_reg    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            xm_reg   <= 1'b0;
            ym_reg   <= 1'b0;
            ov_reg   <= 1'b0;
`endif
        end else if (accept) begin
            cnt_reg  <= '0;
            x_sh_reg <= bus.x;
            y_sh_reg <= bus.y;
            br_reg   <= bus.z;
            acc_reg  <= '0;
`ifdef SUB_OVERFLOW_EN
            xm_reg   <= bus.x[WIDTH-1];
            ym_reg   <= bus.y[WIDTH-1];
`endif
        end else if (state_reg == RUN) begin
            cnt_reg  <= cnt_reg + 1'b1;
            x_sh_reg <= x_sh_reg >> DIGIT;
            y_sh_reg <= y_sh_reg >> DIGIT;
            br_reg   <= bchain[DIGIT];
            acc_reg  <= acc_next;
            if (last) begin
                d_reg  <= acc_next;
                b_reg  <= bchain[DIGIT];
`ifdef SUB_OVERFLOW_EN
                ov_reg <= (xm_reg ^ ym_reg) & (acc_next[WIDTH-1] ^ xm_reg);
`endif
            end
        end
    end

    assign bus.ready = ready_c;
    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.d     = d_reg;
    assign bus.b     = b_reg;
`ifdef SUB_OVERFLOW_EN
    assign bus.ov    = ov_reg;
`endif
endmodule
